// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader: FSM state encoding,
// output buffer depth and the burst counter width helper.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int BUF_DEPTH = 2;

    // Counter must be able to hold the value burst_len itself (saturation point).
    function automatic int cnt_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_skid_buf.sv
// Two-entry registered buffer that absorbs the FIFO read latency; a pushed
// word becomes visible at the head one cycle later, never in the same cycle.
module fifo_rd_skid_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] mem_r [BUF_DEPTH];
    logic                  rd_ptr_r;
    logic                  wr_ptr_r;
    logic [1:0]            occ_r;
    logic                  pop_s;

    // A pop against an empty buffer is ignored so occupancy cannot wrap.
    always_comb begin
        pop_s = 1'b0;
        if (occ_r != 2'd0) begin
            pop_s = pop;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            occ_r <= occ_r + 2'(push) - 2'(pop_s);
        end
    end

    assign occ        = occ_r;
    assign head_valid = (occ_r != 2'd0);
    assign head_data  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer: waits for a full burst in the FIFO, pops exactly
// BURST_LEN words and streams them out with first/last framing.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 11,
    parameter int BURST_LEN   = 16
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    output logic                   fifo_rd_en,
    input  logic                   fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic [DEPTH_WIDTH:0]   fifo_rd_water_level,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_first,
    output logic                   m_last,
    output logic                   busy
);

    localparam int                  CNT_W    = cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0]    CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(BURST_LEN - 1);
    localparam logic [DEPTH_WIDTH:0] LVL_THR = (DEPTH_WIDTH + 1)'(BURST_LEN);

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic                    inflight_r;
    logic [CNT_W-1:0]        issue_cnt_r;
    logic [CNT_W-1:0]        out_cnt_r;
    logic [1:0]              occ_s;
    logic                    head_valid_s;
    logic [DATA_WIDTH-1:0]   head_data_s;
    logic                    pop_out_s;
    logic                    rd_en_s;
    logic                    last_s;

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk        (rd_clk),
        .rst        (rd_rst),
        .push       (inflight_r),
        .push_data  (fifo_rd_data),
        .pop        (pop_out_s),
        .occ        (occ_s),
        .head_valid (head_valid_s),
        .head_data  (head_data_s)
    );

    assign last_s    = head_valid_s && (out_cnt_r == LAST_IDX);
    assign pop_out_s = head_valid_s && m_ready;

    // Next state and pop request; a pop is allowed only if the buffer can
    // still take the word once everything already in flight has landed.
    always_comb begin
        state_nxt_s = state_r;
        rd_en_s     = 1'b0;
        if ((state_r == BURST) && !fifo_rd_empty &&
            ((3'({1'b0, occ_s}) + 3'(inflight_r)) < (3'd2 + 3'(pop_out_s)))) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
        case (state_r)
            IDLE: begin
                if (fifo_rd_water_level >= LVL_THR) begin
                    state_nxt_s = BURST;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                if (rd_en_s && (issue_cnt_r == LAST_IDX)) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = BURST;
                end
            end
            DRAIN: begin
                if (pop_out_s && last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register, in-flight tracking and saturating burst counters.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_r     <= IDLE;
            inflight_r  <= 1'b0;
            issue_cnt_r <= CNT_ZERO;
            out_cnt_r   <= CNT_ZERO;
        end else begin
            state_r    <= state_nxt_s;
            inflight_r <= rd_en_s;
            if ((state_r == IDLE) && (state_nxt_s == BURST)) begin
                issue_cnt_r <= CNT_ZERO;
                out_cnt_r   <= CNT_ZERO;
            end else begin
                if (rd_en_s && (issue_cnt_r != CNT_MAX)) begin
                    issue_cnt_r <= issue_cnt_r + CNT_ONE;
                end
                if (pop_out_s && (out_cnt_r != CNT_MAX)) begin
                    out_cnt_r <= out_cnt_r + CNT_ONE;
                end
            end
        end
    end

    assign fifo_rd_en = rd_en_s;
    assign m_valid    = head_valid_s;
    assign m_data     = head_data_s;
    assign m_first    = head_valid_s && (out_cnt_r == CNT_ZERO);
    assign m_last     = last_s;
    assign busy       = (state_r != IDLE);

endmodule
